// File: rtl/player_pkg.sv
// rtl/player_pkg.sv - shared player direction and sprite-state encodings
package player_pkg;

    // Facing direction, shared with the sprite renderer
    localparam logic [1:0] P_LEFT  = 2'd0;
    localparam logic [1:0] P_RIGHT = 2'd1;
    localparam logic [1:0] P_UP    = 2'd2;
    localparam logic [1:0] P_DOWN  = 2'd3;

    // Sprite state / held-item encoding, shared with the sprite renderer
    localparam logic [3:0] P_NOTHING       = 4'd0;
    localparam logic [3:0] P_CHOPPING      = 4'd1;
    localparam logic [3:0] P_ONION_WHOLE   = 4'd2;
    localparam logic [3:0] P_ONION_CHOPPED = 4'd3;
    localparam logic [3:0] P_PLATE_EMPTY   = 4'd4;
    localparam logic [3:0] P_PLATE_ONION   = 4'd5;
    localparam logic [3:0] P_PAN_EMPTY     = 4'd6;
    localparam logic [3:0] P_PAN_RAW       = 4'd7;
    localparam logic [3:0] P_PAN_COOKED    = 4'd8;
    localparam logic [3:0] P_EXT_OFF       = 4'd9;
    localparam logic [3:0] P_EXT_ON        = 4'd10;

endpackage

// File: rtl/step_calc.sv
// rtl/step_calc.sv - candidate position for one step, clamped to the play-field bounds
module step_calc
    import player_pkg::*;
#(
    parameter int SPEED = 2,
    parameter int X_MIN = 0,
    parameter int X_MAX = 992,
    parameter int Y_MIN = 0,
    parameter int Y_MAX = 736
) (
    input  logic [10:0] x_pos,
    input  logic [9:0]  y_pos,
    input  logic [1:0]  dir,
    output logic [10:0] cand_x,
    output logic [9:0]  cand_y
);

    // Thresholds are compared before stepping so the unsigned result never wraps
    localparam logic [10:0] X_LO     = 11'(X_MIN + SPEED);
    localparam logic [10:0] X_HI     = 11'(X_MAX - SPEED);
    localparam logic [10:0] X_MIN_V  = 11'(X_MIN);
    localparam logic [10:0] X_MAX_V  = 11'(X_MAX);
    localparam logic [10:0] X_STEP   = 11'(SPEED);
    localparam logic [9:0]  Y_LO     = 10'(Y_MIN + SPEED);
    localparam logic [9:0]  Y_HI     = 10'(Y_MAX - SPEED);
    localparam logic [9:0]  Y_MIN_V  = 10'(Y_MIN);
    localparam logic [9:0]  Y_MAX_V  = 10'(Y_MAX);
    localparam logic [9:0]  Y_STEP   = 10'(SPEED);

    // Move one axis by SPEED toward the requested direction, saturating at the bound
    always_comb begin
        cand_x = x_pos;
        cand_y = y_pos;
        case (dir)
            P_LEFT:  cand_x = (x_pos < X_LO) ? X_MIN_V : x_pos - X_STEP;
            P_RIGHT: cand_x = (x_pos > X_HI) ? X_MAX_V : x_pos + X_STEP;
            P_UP:    cand_y = (y_pos < Y_LO) ? Y_MIN_V : y_pos - Y_STEP;
            default: cand_y = (y_pos > Y_HI) ? Y_MAX_V : y_pos + Y_STEP;
        endcase
    end

endmodule

// File: rtl/player_motion_ctrl.sv
// rtl/player_motion_ctrl.sv - per-player motion, collision handshake, chop timer and sprite state
module player_motion_ctrl
    import player_pkg::*;
#(
    parameter int SPEED       = 2,
    parameter int X_INIT      = 100,
    parameter int Y_INIT      = 100,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 992,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 736,
    parameter int CHOP_FRAMES = 90
) (
    input  logic        pixel_clk_in,
    input  logic        rst_n_in,
    input  logic        frame_tick_in,
    input  logic        btn_up_in,
    input  logic        btn_down_in,
    input  logic        btn_left_in,
    input  logic        btn_right_in,
    input  logic        btn_chop_in,
    input  logic        btn_spray_in,
    input  logic        at_board_in,
    input  logic [3:0]  held_item_in,
    output logic        move_req_out,
    output logic [10:0] move_x_out,
    output logic [9:0]  move_y_out,
    input  logic        move_ack_in,
    input  logic        move_ok_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic [1:0]  player_direction,
    output logic [3:0]  player_state,
    output logic        chop_done_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_CHOP = 2'd2;

    localparam int               CNT_W     = $clog2(CHOP_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CHOP_FRAMES - 1);

    logic [1:0]       fsm_q;
    logic [CNT_W-1:0] chop_cnt_q;
    logic             any_dir;
    logic [1:0]       dir_sel;
    logic [10:0]      cand_x;
    logic [9:0]       cand_y;

    assign any_dir = btn_up_in | btn_down_in | btn_left_in | btn_right_in;

    // Resolve simultaneous direction buttons: up > down > left > right
    always_comb begin
        dir_sel = P_RIGHT;
        if (btn_up_in)
            dir_sel = P_UP;
        else if (btn_down_in)
            dir_sel = P_DOWN;
        else if (btn_left_in)
            dir_sel = P_LEFT;
    end

    step_calc #(
        .SPEED (SPEED),
        .X_MIN (X_MIN),
        .X_MAX (X_MAX),
        .Y_MIN (Y_MIN),
        .Y_MAX (Y_MAX)
    ) u_step_calc (
        .x_pos  (x_out),
        .y_pos  (y_out),
        .dir    (dir_sel),
        .cand_x (cand_x),
        .cand_y (cand_y)
    );

    // Movement/chop FSM: a step is only committed once the collision map grants it
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            fsm_q            <= S_IDLE;
            x_out            <= 11'(X_INIT);
            y_out            <= 10'(Y_INIT);
            player_direction <= P_DOWN;
            move_req_out     <= 1'b0;
            move_x_out       <= 11'(X_INIT);
            move_y_out       <= 10'(Y_INIT);
            chop_cnt_q       <= '0;
            chop_done_out    <= 1'b0;
        end else begin
            chop_done_out <= 1'b0;
            case (fsm_q)
                S_IDLE: begin
                    if (frame_tick_in) begin
                        if (any_dir) begin
                            player_direction <= dir_sel;
                            move_req_out     <= 1'b1;
                            move_x_out       <= cand_x;
                            move_y_out       <= cand_y;
                            fsm_q            <= S_REQ;
                        end else if (btn_chop_in && at_board_in &&
                                     held_item_in == P_NOTHING &&
                                     player_direction != P_UP) begin
                            fsm_q      <= S_CHOP;
                            chop_cnt_q <= '0;
                        end
                    end
                end
                S_REQ: begin
                    // Frame ticks are deliberately ignored until the map answers
                    if (move_ack_in) begin
                        move_req_out <= 1'b0;
                        if (move_ok_in) begin
                            x_out <= move_x_out;
                            y_out <= move_y_out;
                        end
                        fsm_q <= S_IDLE;
                    end
                end
                S_CHOP: begin
                    if (frame_tick_in) begin
                        if (!btn_chop_in || !at_board_in || any_dir) begin
                            fsm_q      <= S_IDLE;
                            chop_cnt_q <= '0;
                        end else if (chop_cnt_q == CNT_LAST) begin
                            chop_done_out <= 1'b1;
                            fsm_q         <= S_IDLE;
                            chop_cnt_q    <= '0;
                        end else begin
                            chop_cnt_q <= chop_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: fsm_q <= S_IDLE;
            endcase
        end
    end

    // Sprite state: chopping overrides, then the active extinguisher, then the held item
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            player_state <= P_NOTHING;
        else if (fsm_q == S_CHOP)
            player_state <= P_CHOPPING;
        else if (held_item_in == P_EXT_OFF && btn_spray_in)
            player_state <= P_EXT_ON;
        else if (held_item_in == P_CHOPPING || held_item_in > P_EXT_ON)
            player_state <= P_NOTHING;
        else
            player_state <= held_item_in;
    end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// tb/tb_player_motion_ctrl.sv - scoreboard bench for player_motion_ctrl
module tb_player_motion_ctrl;

    localparam int CHOP_N = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        tick = 1'b0;
    logic        bu = 1'b0, bd = 1'b0, bl = 1'b0, br = 1'b0;
    logic        chop = 1'b0, spray = 1'b0, board = 1'b0;
    logic [3:0]  held = 4'd0;
    logic        ack = 1'b0, ok = 1'b0;
    logic        move_req_out;
    logic [10:0] move_x_out;
    logic [9:0]  move_y_out;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic [1:0]  player_direction;
    logic [3:0]  player_state;
    logic        chop_done_out;

    player_motion_ctrl #(.CHOP_FRAMES(CHOP_N)) dut (
        .pixel_clk_in     (clk),
        .rst_n_in         (rst_n),
        .frame_tick_in    (tick),
        .btn_up_in        (bu),
        .btn_down_in      (bd),
        .btn_left_in      (bl),
        .btn_right_in     (br),
        .btn_chop_in      (chop),
        .btn_spray_in     (spray),
        .at_board_in      (board),
        .held_item_in     (held),
        .move_req_out     (move_req_out),
        .move_x_out       (move_x_out),
        .move_y_out       (move_y_out),
        .move_ack_in      (ack),
        .move_ok_in       (ok),
        .x_out            (x_out),
        .y_out            (y_out),
        .player_direction (player_direction),
        .player_state     (player_state),
        .chop_done_out    (chop_done_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct { int d; int x; int y; } req_t;
    typedef struct { int x; int y; } pos_t;
    req_t req_q[$];
    pos_t pos_q[$];
    int   chop_q[$];

    // Reference model: position, facing, chopping flag and ticks spent chopping
    int m_x = 100, m_y = 100, m_dir = 3, m_mode = 0, m_ticks = 0, chop_seq = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // One frame: drive inputs with a tick, model its effect, play the collision map if a step is requested
    task automatic do_frame(input logic [3:0] dirs, input logic c, input logic b,
                            input logic [3:0] h, input logic s,
                            input int ack_dly, input logic k, input int tmode);
        req_t e;
        pos_t p;
        bit   go;
        int   w;
        go = 1'b0;
        e.d = 0; e.x = 0; e.y = 0;
        @(negedge clk);
        {bu, bd, bl, br} = dirs;
        chop = c; board = b; held = h; spray = s; tick = 1'b1;
        if (m_mode == 0) begin
            if (dirs != 4'd0) begin
                e.d = dirs[3] ? 2 : (dirs[2] ? 3 : (dirs[1] ? 0 : 1));
                e.x = m_x; e.y = m_y;
                case (e.d)
                    0: e.x = clampi(m_x - 2, 0, 992);
                    1: e.x = clampi(m_x + 2, 0, 992);
                    2: e.y = clampi(m_y - 2, 0, 736);
                    default: e.y = clampi(m_y + 2, 0, 736);
                endcase
                m_dir = e.d;
                req_q.push_back(e);
                go = 1'b1;
            end else if (c && b && h == 4'd0 && m_dir != 2) begin
                m_mode = 1;
                m_ticks = 0;
            end
        end else begin
            if (!c || !b || dirs != 4'd0) begin
                m_mode = 0;
            end else begin
                m_ticks++;
                if (m_ticks == CHOP_N) begin
                    chop_q.push_back(chop_seq);
                    chop_seq++;
                    m_mode = 0;
                end
            end
        end
        @(negedge clk);
        tick = 1'b0;
        if (go) begin
            w = 0;
            while (!move_req_out && w < 10) begin
                @(negedge clk);
                w++;
            end
            if (!move_req_out) begin
                checks++;
                errors++;
                $display("FAIL req_timeout: move_req_out=%0d expected 1", move_req_out);
            end else begin
                for (int i = 0; i < ack_dly; i++) begin
                    if (tmode == 1 && i == 0) tick = 1'b1;
                    @(negedge clk);
                    tick = 1'b0;
                end
                ack = 1'b1;
                ok = k;
                if (tmode == 2) tick = 1'b1;
                if (k) begin
                    m_x = e.x;
                    m_y = e.y;
                end
                p.x = m_x; p.y = m_y;
                pos_q.push_back(p);
                @(negedge clk);
                ack = 1'b0; ok = 1'b0; tick = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_x"}, x_out, 100);
        chk({tag, "_y"}, y_out, 100);
        chk({tag, "_dir"}, player_direction, 3);
        chk({tag, "_state"}, player_state, 0);
        chk({tag, "_req"}, move_req_out, 0);
        chk({tag, "_done"}, chop_done_out, 0);
    endtask

    // Monitor: compares every DUT presentation against the scoreboard queues
    initial begin
        int   exp_state;
        int   mode_snap;
        bit   ack_s, prev_req, prev_done;
        int   last_cx, last_cy, done_seen;
        req_t e;
        pos_t p;
        mode_snap = 0; prev_req = 0; prev_done = 0; last_cx = 0; last_cy = 0; done_seen = 0;
        forever begin
            @(posedge clk);
            if (mode_snap != 0)
                exp_state = 1;
            else if (held == 4'd9 && spray)
                exp_state = 10;
            else if (held == 4'd1 || held > 4'd10)
                exp_state = 0;
            else
                exp_state = int'(held);
            ack_s = ack;
            #1;
            if (mon_en && rst_n) begin
                chk("player_state", player_state, exp_state);
                if (move_req_out && !prev_req) begin
                    if (req_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_req: move_req_out=1 expected 0");
                    end else begin
                        e = req_q.pop_front();
                        chk("req_dir", player_direction, e.d);
                        chk("req_cand_x", move_x_out, e.x);
                        chk("req_cand_y", move_y_out, e.y);
                    end
                    last_cx = move_x_out;
                    last_cy = move_y_out;
                end else if (move_req_out && prev_req) begin
                    chk("req_hold_x", move_x_out, last_cx);
                    chk("req_hold_y", move_y_out, last_cy);
                end
                if (ack_s) begin
                    chk("req_drop", move_req_out, 0);
                    if (pos_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_ack: pos queue size=0 expected 1");
                    end else begin
                        p = pos_q.pop_front();
                        chk("commit_x", x_out, p.x);
                        chk("commit_y", y_out, p.y);
                    end
                end
                if (chop_done_out) begin
                    chk("chop_done_width", prev_done, 0);
                    if (chop_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_chop_done: pulse=1 expected 0");
                    end else begin
                        chk("chop_done_seq", done_seen, chop_q.pop_front());
                    end
                    done_seen++;
                end
                mode_snap = m_mode;
            end else begin
                mode_snap = 0;
            end
            prev_req = mon_en ? move_req_out : 1'b0;
            prev_done = mon_en ? chop_done_out : 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        #2 rst_n = 1'b0;
        #1 chk("in_reset_req", move_req_out, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        #1 check_reset_vals("reset");

        // Right step granted after a 3-cycle wait
        do_frame(4'b0001, 0, 0, 4'd0, 0, 3, 1'b1, 0);
        chk("right_x", x_out, 102);
        chk("right_dir", player_direction, 1);

        // Walk to the left edge, then push against it (granted and refused)
        while (m_x > 0) do_frame(4'b0010, 0, 0, 4'd0, 0, 0, 1'b1, 0);
        do_frame(4'b0010, 0, 0, 4'd0, 0, 1, 1'b0, 0);
        do_frame(4'b0010, 0, 0, 4'd0, 0, 0, 1'b1, 0);
        chk("left_edge_x", x_out, 0);

        // Up and down together: up wins; stray ticks during REQ and on the ack
        do_frame(4'b1100, 0, 0, 4'd0, 0, 2, 1'b1, 1);
        do_frame(4'b1100, 0, 0, 4'd0, 0, 1, 1'b0, 2);
        chk("updown_dir", player_direction, 2);

        // Chop refused while facing up
        do_frame(4'b0000, 1, 1, 4'd0, 0, 0, 1'b0, 0);
        do_frame(4'b0000, 1, 1, 4'd0, 0, 0, 1'b0, 0);
        // Face down without moving, then a full chop
        do_frame(4'b0100, 0, 0, 4'd0, 0, 0, 1'b0, 0);
        for (int i = 0; i < 1 + CHOP_N; i++) do_frame(4'b0000, 1, 1, 4'd0, 0, 0, 1'b0, 0);
        do_frame(4'b0000, 0, 0, 4'd0, 0, 0, 1'b0, 0);
        // Aborts: chop released on tick 2, board lost, direction pressed
        do_frame(4'b0000, 1, 1, 4'd0, 0, 0, 1'b0, 0);
        do_frame(4'b0000, 1, 1, 4'd0, 0, 0, 1'b0, 0);
        do_frame(4'b0000, 0, 1, 4'd0, 0, 0, 1'b0, 0);
        do_frame(4'b0000, 1, 1, 4'd0, 0, 0, 1'b0, 0);
        do_frame(4'b0000, 1, 0, 4'd0, 0, 0, 1'b0, 0);
        do_frame(4'b0000, 1, 1, 4'd0, 0, 0, 1'b0, 0);
        do_frame(4'b0000, 1, 1, 4'd0, 0, 0, 1'b0, 0);
        do_frame(4'b0001, 1, 1, 4'd0, 0, 0, 1'b0, 0);

        // Sprite state mapping
        do_frame(4'b0000, 0, 0, 4'd9, 1, 0, 1'b0, 0);
        chk("ext_on_state", player_state, 10);
        do_frame(4'b0000, 0, 0, 4'd9, 0, 0, 1'b0, 0);
        do_frame(4'b0000, 0, 0, 4'd1, 0, 0, 1'b0, 0);
        chk("held1_state", player_state, 0);
        do_frame(4'b0000, 0, 0, 4'd12, 1, 0, 1'b0, 0);
        chk("held12_state", player_state, 0);
        do_frame(4'b0000, 0, 0, 4'd5, 0, 0, 1'b0, 0);

        // Remaining edges: top, bottom, right
        while (m_y > 0) do_frame(4'b1000, 0, 0, 4'd0, 0, 0, 1'b1, 0);
        do_frame(4'b1000, 0, 0, 4'd0, 0, 0, 1'b1, 0);
        while (m_y < 736) do_frame(4'b0100, 0, 0, 4'd0, 0, 0, 1'b1, 0);
        do_frame(4'b0100, 0, 0, 4'd0, 0, 0, 1'b1, 0);
        chk("bottom_edge_y", y_out, 736);
        while (m_x < 992) do_frame(4'b0001, 0, 0, 4'd0, 0, 0, 1'b1, 0);
        do_frame(4'b0001, 0, 0, 4'd0, 0, 0, 1'b1, 0);
        chk("right_edge_x", x_out, 992);

        // Randomized frames
        for (int n = 0; n < 300; n++) begin
            logic [3:0] dirs, h;
            dirs = ($urandom % 3 == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            h = ($urandom % 3 == 0) ? 4'($urandom % 16) : 4'd0;
            do_frame(dirs, 1'($urandom % 5 != 0), 1'($urandom % 6 != 0), h,
                     1'($urandom % 2), int'($urandom % 4), 1'($urandom % 2),
                     int'($urandom % 3));
        end

        // Reset while a request is outstanding, then a late ack in IDLE
        do_frame(4'b0000, 0, 0, 4'd0, 0, 0, 1'b0, 0);
        @(negedge clk);
        bd = 1'b1; tick = 1'b1;
        begin
            req_t e;
            e.d = 3; e.x = m_x; e.y = clampi(m_y + 2, 0, 736);
            req_q.push_back(e);
        end
        @(negedge clk);
        tick = 1'b0; bd = 1'b0;
        @(negedge clk);
        chk("pre_reset_req", move_req_out, 1);
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1 chk("reset_drops_req", move_req_out, 0);
        m_x = 100; m_y = 100; m_dir = 3; m_mode = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        #1 check_reset_vals("midreq_reset");
        @(negedge clk);
        ack = 1'b1; ok = 1'b1;
        begin
            pos_t p;
            p.x = 100; p.y = 100;
            pos_q.push_back(p);
        end
        @(negedge clk);
        ack = 1'b0; ok = 1'b0;
        repeat (4) @(negedge clk);
        chk("late_ack_dir", player_direction, 3);

        chk("pending_req", req_q.size(), 0);
        chk("pending_pos", pos_q.size(), 0);
        chk("pending_chop", chop_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
